// File: rtl/spi_master_interface.sv
// SPI initiator on the shared system clock: frames a 2-bit command plus 8-bit payload
// onto SS_n/MOSI and, for read-data commands, captures the 8-bit reply from MISO.
module spi_master_interface #(
  parameter int RD_WAIT = 2,
  parameter int ADDR_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);

  localparam int         RD_WAIT_C  = (RD_WAIT < 1) ? 1 : ((RD_WAIT > 15) ? 15 : RD_WAIT);
  localparam logic [3:0] WAIT_INIT  = 4'(RD_WAIT_C - 1);
  localparam logic [3:0] SHIFT_INIT = 4'(ADDR_W + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEL   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] frame_q, frame_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        // ready comes up one cycle after reset releases; accept only once it is visible
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (cmd_valid) begin
          frame_d = {cmd, cmd_data};
          state_d = ST_SEL;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = cmd[1];
        end
      end
      ST_SEL: begin
        state_d = ST_SHIFT;
        cnt_d   = SHIFT_INIT;
        mosi_d  = frame_q[ADDR_W+1];
      end
      ST_SHIFT: begin
        if (cnt_q == 4'd0) begin
          mosi_d = 1'b0;
          if (frame_q[ADDR_W+1:ADDR_W] == 2'b11) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_END;
            ss_n_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          mosi_d = frame_q[cnt_q - 4'd1];
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECV;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECV: begin
        rx_d = {rx_q[6:0], MISO};
        if (cnt_q == 4'd0) begin
          state_d    = ST_END;
          ss_n_d     = 1'b1;
          rd_data_d  = {rx_q[6:0], MISO};
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= '0;
      rx_q       <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/spi_master_interface.md
Name: spi_master_interface

Overview:
- Initiator end of the single-clock SPI link to the SPI slave/RAM block.
- Accepts 2-bit command + 8-bit payload from a host via valid/ready handshake; frames onto SS_n/MOSI; for read-data commands, captures the 8-bit reply from MISO and returns it to the host.
- SPI pins are sampled/driven on the shared system clock. No separate SCLK.

Parameters:
- RD_WAIT, 2, turnaround cycles between last MOSI bit and first MISO capture for cmd 2'b11; legal 1..15
- ADDR_W, 8, payload width; frame length = ADDR_W+2; only 8 is supported, reserved for future

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  host request valid
- cmd_ready  output  1  high only in IDLE; transfer accepted when cmd_valid && cmd_ready
- cmd  input  2  00 write addr, 01 write data, 10 read addr, 11 read data
- cmd_data  input  8  address or data payload
- SS_n  output  1  slave select, active-low
- MOSI  output  1  serial data to slave, MSB first
- MISO  input  1  serial data from slave, MSB first
- rd_data  output  8  captured read byte
- rd_valid  output  1  one-cycle pulse, rd_data valid (cmd 11 only)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (any cycle rst=1): state IDLE, SS_n=1, MOSI=0, cmd_ready=0 during reset then 1 in IDLE, rd_valid=0, rd_data=0, busy=0, counters cleared.
- All outputs are registered. An output "in state X" takes its value at the edge entering X.
- Accept edge T (cmd_valid && cmd_ready): latch frame = {cmd, cmd_data} (10 bits). Inputs are ignored at all other times.
- States:
  - IDLE: SS_n=1, MOSI=0, cmd_ready=1. On accept, go to SEL.
  - SEL (1 cycle, T+1): SS_n=0, MOSI=cmd[1] (slave's write/read select bit). Go to SHIFT.
  - SHIFT (10 cycles, T+2..T+11): MOSI = frame[9], frame[8], ..., frame[0]; 4-bit down counter 9→0. After bit 0: go to WAIT if cmd==11, else END.
  - WAIT (RD_WAIT cycles): SS_n=0, MOSI=0. Go to RECV.
  - RECV (8 cycles): SS_n=0, MOSI=0. At each edge ending a RECV cycle, shift MISO into rx shift register LSB side (first captured bit ends as rd_data[7]). Go to END.
  - END (1 cycle): SS_n=1, MOSI=0. If cmd==11, rd_data=rx shift register and rd_valid=1 this cycle only. Go to IDLE.
- Timing:
  - Write / read-addr: SS_n low for 11 cycles (T+1..T+11), END at T+12, cmd_ready high at T+13.
  - Read-data with RD_WAIT=2: WAIT T+12..T+13, RECV T+14..T+21, END T+22 (rd_valid), ready T+23.
- SS_n always high ≥2 consecutive cycles between frames (END + IDLE), so the slave returns to IDLE.
- rd_data holds its value until the next cmd-11 END or reset. rd_valid never asserts for cmd 00/01/10.
- cmd_valid held high across frames: next accept is on the first IDLE cycle. No back-to-back without an IDLE.
- Host changing cmd/cmd_data mid-frame has no effect (latched copy).
- rst asserted mid-frame: next edge forces the reset values (SS_n=1 immediately). No rd_valid. Partial frame is discarded.
- RD_WAIT out of range: implementation clamps to 1..15 at elaboration.

Test Plan:
- Reset: hold rst 3 cycles mid-SHIFT → next edge SS_n=1, MOSI=0, busy=0, rd_valid=0; cmd_ready=1 one cycle after rst drops.
- Write addr: cmd=00, cmd_data=8'hA5 accepted at T → MOSI T+1..T+11 = 0, 0,0,1,0,1,0,0,1,0,1; SS_n low T+1..T+11, high T+12; no rd_valid.
- Read-data: cmd=11, RD_WAIT=2, MISO driven 1,0,1,1,0,0,1,0 in T+14..T+21 → rd_valid=1 only at T+22, rd_data=8'hB2.
- Back-to-back: cmd_valid held high with cmd=01/8'h3C then 10/8'h07 → second accept exactly 2 cycles after first SS_n rise; SS_n high exactly 2 cycles between frames.
- Abort: rst pulsed during RECV of cmd 11 → no rd_valid; rd_data=0; next cmd-11 frame returns correct byte.
- End to end: with the SPI slave + RAM, write addr 8'h10, write data 8'h5A, read addr 8'h10, read data → rd_data=8'h5A.
